// File: rtl/sun2_dvma_pkg.sv
// Shared definitions for the 120-board DVMA sequencer.
//  dvma_state_t    : sequencer state encoding
//  DEF_WAIT_STATES : default RUN length before c_s7
//  DEF_REQ_TIMEOUT : default REQ length before giving up on a grant
//  cnt_width()     : counter width able to hold the larger of two terminal counts
package sun2_dvma_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      GRANT   = 3'd2,
      RUN     = 3'd3,
      XACK    = 3'd4,
      RELEASE = 3'd5,
      BLOCK   = 3'd6
   } dvma_state_t;

   localparam int unsigned DEF_WAIT_STATES = 6;
   localparam int unsigned DEF_REQ_TIMEOUT = 255;

   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      cnt_width = $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/dvma_cycle_counter.sv
// Clear/enable saturating counter with a terminal-count compare.
//  clk, reset : clock, async active-high reset
//  clr        : synchronous clear (wins over en)
//  en         : count enable
//  tc_value   : terminal value to compare against
//  tc         : count == tc_value (combinational on the current count)
module dvma_cycle_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] tc_value,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != '1))   // saturate, never wrap
         count <= count + 1'b1;
   end

   assign tc = (count == tc_value);

endmodule

// File: rtl/dvma_sequencer.sv
// DVMA cycle sequencer: arbitrates the 68010 bus for a DVMA request,
// drives xen for the cycle and raises c_s7 after a fixed wait count.
//  clk, reset            : board clock, async active-high reset
//  en_dvma, xreq         : enable gate and request from the decoder
//  p1_mrdc, p1_mrwc      : P1 master commands; the bus is held while either is up
//  cpu_bg, cpu_as        : 68010 grant and address strobe
//  cpu_bgack_in          : wired-OR BGACK read-back from other masters
//  cpu_br, cpu_bgack     : bus request / grant acknowledge to the 68010
//  xen, c_s7             : address/control enable and xack qualifier to the decoder
//  dvma_busy             : state != IDLE
//  dvma_timeout          : one-clock pulse on giving up in REQ
module dvma_sequencer
   import sun2_dvma_pkg::*;
#(
   parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
   parameter int unsigned REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic en_dvma,
   input  logic xreq,
   input  logic p1_mrdc,
   input  logic p1_mrwc,
   input  logic cpu_bg,
   input  logic cpu_as,
   input  logic cpu_bgack_in,
   output logic cpu_br,
   output logic cpu_bgack,
   output logic xen,
   output logic c_s7,
   output logic dvma_busy,
   output logic dvma_timeout
);

   localparam int unsigned CW = cnt_width(WAIT_STATES, REQ_TIMEOUT);
   localparam logic [CW-1:0] RUN_TC = CW'(WAIT_STATES - 1);
   localparam logic [CW-1:0] REQ_TC = CW'(REQ_TIMEOUT - 1);

   dvma_state_t state, next_state;

   logic grant_ok, cmd_active;
   logic cnt_clr, cnt_en, cnt_tc;
   logic [CW-1:0] cnt_tc_value;
   logic br_d, bgack_d, xen_d, c_s7_d, busy_d, timeout_d;

   // Bus is ours only when granted, idle, and no other master holds BGACK.
   assign grant_ok   = cpu_bg & ~cpu_as & ~cpu_bgack_in;
   assign cmd_active = p1_mrdc | p1_mrwc;

   // One counter serves REQ (timeout) and RUN (wait states); it sits at
   // zero in every other state so each of those starts from 0.
   assign cnt_en       = (state == REQ) || (state == RUN);
   assign cnt_clr      = ~cnt_en;
   assign cnt_tc_value = (state == REQ) ? REQ_TC : RUN_TC;

   dvma_cycle_counter #(.WIDTH(CW)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .tc_value (cnt_tc_value),
      .tc       (cnt_tc)
   );

   // State and registered outputs. Async reset drops BR/BGACK/xen at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cpu_br       <= 1'b0;
         cpu_bgack    <= 1'b0;
         xen          <= 1'b0;
         c_s7         <= 1'b0;
         dvma_busy    <= 1'b0;
         dvma_timeout <= 1'b0;
      end else begin
         state        <= next_state;
         cpu_br       <= br_d;
         cpu_bgack    <= bgack_d;
         xen          <= xen_d;
         c_s7         <= c_s7_d;
         dvma_busy    <= busy_d;
         dvma_timeout <= timeout_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (en_dvma && xreq) next_state = REQ;
         REQ: begin
            // grant beats withdrawal, withdrawal beats timeout
            if (grant_ok)    next_state = GRANT;
            else if (!xreq)  next_state = IDLE;
            else if (cnt_tc) next_state = BLOCK;
         end
         GRANT:   next_state = RUN;
         RUN: begin
            if (!xreq)       next_state = RELEASE;
            else if (cnt_tc) next_state = XACK;
         end
         XACK:    if (!cmd_active) next_state = RELEASE;
         RELEASE: next_state = IDLE;
         BLOCK:   if (!xreq) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs decoded from the state being entered, so the registers
   // above present a pure function of the current state.
   always_comb begin
      br_d      = 1'b0;
      bgack_d   = 1'b0;
      xen_d     = 1'b0;
      c_s7_d    = 1'b0;
      busy_d    = (next_state != IDLE);
      timeout_d = (state == REQ) && (next_state == BLOCK);
      case (next_state)
         REQ:     br_d = 1'b1;
         GRANT,
         RUN: begin
            bgack_d = 1'b1;
            xen_d   = 1'b1;
         end
         XACK: begin
            bgack_d = 1'b1;
            xen_d   = 1'b1;
            c_s7_d  = 1'b1;
         end
         // BGACK held one more clock so xen falls inside it
         RELEASE: bgack_d = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dvma_sequencer.sv
module tb_dvma_sequencer;

   localparam int unsigned WS = 6;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en_dvma = 1'b0, xreq = 1'b0, p1_mrdc = 1'b0, p1_mrwc = 1'b0;
   logic cpu_bg = 1'b0, cpu_as = 1'b0, cpu_bgack_in = 1'b0;
   logic cpu_br, cpu_bgack, xen, c_s7, dvma_busy, dvma_timeout;

   int tests = 0;
   int fails = 0;
   bit done  = 1'b0;

   always #5 clk = ~clk;

   dvma_sequencer #(.WAIT_STATES(WS), .REQ_TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .en_dvma      (en_dvma),
      .xreq         (xreq),
      .p1_mrdc      (p1_mrdc),
      .p1_mrwc      (p1_mrwc),
      .cpu_bg       (cpu_bg),
      .cpu_as       (cpu_as),
      .cpu_bgack_in (cpu_bgack_in),
      .cpu_br       (cpu_br),
      .cpu_bgack    (cpu_bgack),
      .xen          (xen),
      .c_s7         (c_s7),
      .dvma_busy    (dvma_busy),
      .dvma_timeout (dvma_timeout)
   );

   // Behavioural model: tracks what the block is doing as a set of facts
   // (requesting, owning the bus, acknowledging, releasing, blocked) plus
   // elapsed-clock counts, and derives the pins from those facts.
   bit m_req, m_own, m_ack, m_rel, m_blk, m_pulse;
   int m_age, m_xen_age;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_req = 0; m_own = 0; m_ack = 0; m_rel = 0; m_blk = 0; m_pulse = 0;
         m_age = 0; m_xen_age = 0;
      end else begin
         m_pulse = 0;
         if (m_req) begin
            if (cpu_bg && !cpu_as && !cpu_bgack_in) begin
               m_req = 0; m_own = 1; m_xen_age = 0;
            end else if (!xreq) begin
               m_req = 0;
            end else if (m_age + 1 == TO) begin
               m_req = 0; m_blk = 1; m_pulse = 1;
            end else begin
               m_age++;
            end
         end else if (m_own && !m_ack) begin
            // m_xen_age: clocks of xen already shown (grant clock = 0)
            if (m_xen_age == 0)          m_xen_age = 1;
            else if (!xreq)              begin m_own = 0; m_rel = 1; end
            else if (m_xen_age == WS)    m_ack = 1;
            else                         m_xen_age++;
         end else if (m_ack) begin
            if (!(p1_mrdc || p1_mrwc)) begin m_ack = 0; m_own = 0; m_rel = 1; end
         end else if (m_rel) begin
            m_rel = 0;
         end else if (m_blk) begin
            if (!xreq) m_blk = 0;
         end else if (en_dvma && xreq) begin
            m_req = 1; m_age = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!done) begin
         logic [5:0] act, exp;
         act = {cpu_br, cpu_bgack, xen, c_s7, dvma_busy, dvma_timeout};
         exp = {m_req, m_own | m_rel, m_own, m_ack, m_req | m_own | m_rel | m_blk, m_pulse};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL model_cmp t=%0t got br,bgack,xen,c_s7,busy,to=%b want %b", $time, act, exp);
         end
         tests++;
         if (cpu_br && xen) begin
            fails++;
            $display("FAIL br_xen_exclusive t=%0t got br=1 xen=1 want not both", $time);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   initial begin
      int n;
      bit found;

      // 1. reset, then release with a pending request
      tick(2);
      check("rst_br", cpu_br, 1'b0);
      check("rst_bgack", cpu_bgack, 1'b0);
      check("rst_busy", dvma_busy, 1'b0);
      en_dvma = 1; xreq = 1;
      reset = 0;
      check("rst_xen", xen, 1'b0);
      tick(1);
      check("t1_br", cpu_br, 1'b1);
      check("t1_xen", xen, 1'b0);
      check("t1_bgack", cpu_bgack, 1'b0);
      check("t1_c_s7", c_s7, 1'b0);
      check("t1_to", dvma_timeout, 1'b0);

      // 2. full write cycle
      p1_mrwc = 1;
      tick(2);
      cpu_bg = 1;
      tick(1);
      check("t2_xen_on", xen, 1'b1);
      check("t2_br_off", cpu_br, 1'b0);
      cpu_bg = 0;
      n = 0; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1); n++;
         if (c_s7) found = 1;
      end
      check("t2_c_s7_seen", found, 1'b1);
      check_int("t2_xen_to_c_s7", n, 7);
      tick(3);
      check("t2_c_s7_hold", c_s7, 1'b1);
      p1_mrwc = 0;
      tick(1);
      check("t2_xen_drop", xen, 1'b0);
      check("t2_bgack_hold", cpu_bgack, 1'b1);
      xreq = 0;
      tick(1);
      check("t2_bgack_drop", cpu_bgack, 1'b0);
      check("t2_busy_drop", dvma_busy, 1'b0);

      // 3. grant never arrives
      xreq = 1;
      tick(1);
      check("t3_br", cpu_br, 1'b1);
      n = 0; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1); n++;
         if (dvma_timeout) found = 1;
      end
      check("t3_to_seen", found, 1'b1);
      check_int("t3_to_clk", n, 16);
      check("t3_br_off", cpu_br, 1'b0);
      tick(1);
      check("t3_to_pulse_end", dvma_timeout, 1'b0);
      tick(2);
      check("t3_no_rereq", cpu_br, 1'b0);
      xreq = 0;
      tick(1);
      check("t3_unblock", dvma_busy, 1'b0);
      xreq = 1;
      tick(1);
      check("t3_rereq", cpu_br, 1'b1);

      // 4. bus busy, then foreign BGACK
      cpu_bg = 1; cpu_as = 1;
      tick(5);
      check("t4_as_hold_br", cpu_br, 1'b1);
      check("t4_as_hold_xen", xen, 1'b0);
      cpu_as = 0;
      tick(1);
      check("t4_as_grant", xen, 1'b1);
      xreq = 0; cpu_bg = 0;
      tick(3);
      check("t4_idle1", dvma_busy, 1'b0);
      cpu_bg = 1; cpu_bgack_in = 1; xreq = 1;
      tick(5);
      check("t4_bgack_hold_br", cpu_br, 1'b1);
      check("t4_bgack_hold_xen", xen, 1'b0);
      cpu_bgack_in = 0;
      tick(1);
      check("t4_bgack_grant", xen, 1'b1);
      xreq = 0; cpu_bg = 0;
      tick(3);
      check("t4_idle2", dvma_busy, 1'b0);

      // 5. abort at RUN clock 3
      xreq = 1; cpu_bg = 1;
      tick(2);
      check("t5_xen", xen, 1'b1);
      cpu_bg = 0;
      tick(3);
      check("t5_run3_c_s7", c_s7, 1'b0);
      xreq = 0;
      tick(1);
      check("t5_rel_xen", xen, 1'b0);
      check("t5_rel_c_s7", c_s7, 1'b0);
      check("t5_rel_bgack", cpu_bgack, 1'b1);
      tick(1);
      check("t5_idle", dvma_busy, 1'b0);

      // 6. reset during XACK, then blocked by en_dvma
      xreq = 1; cpu_bg = 1; p1_mrdc = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (c_s7) found = 1;
      end
      check("t6_xack_seen", found, 1'b1);
      cpu_bg = 0;
      tick(2);
      check("t6_xack_hold", c_s7, 1'b1);
      reset = 1;
      #1;
      check("t6_rst_xen", xen, 1'b0);
      check("t6_rst_c_s7", c_s7, 1'b0);
      check("t6_rst_bgack", cpu_bgack, 1'b0);
      en_dvma = 0; p1_mrdc = 0;
      tick(2);
      reset = 0;
      tick(4);
      check("t6_gated_busy", dvma_busy, 1'b0);
      check("t6_gated_br", cpu_br, 1'b0);

      done = 1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
